// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_add_pkg;

  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_bit.sv
// Combinational 1-bit full adder cell used by the serial datapath.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ cin;
  assign co = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB-first, busy/done handshake.
// Optional subtract mode (sub port, a-b) enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   op_a_r;
  logic [WIDTH-1:0]   op_b_r;
  logic [WIDTH-1:0]   res_r;
  logic [WIDTH-1:0]   sum_r;
  logic               carry_r;
  logic               cout_r;
  logic               busy_r;
  logic               done_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               last_s;
  logic               fa_s_s;
  logic               fa_co_s;
  logic               busy_nxt_s;
  logic               done_nxt_s;
  logic [WIDTH-1:0]   load_b_s;
  logic               load_c_s;

  fa_bit u_fa (
    .x   (op_a_r[0]),
    .y   (op_b_r[0]),
    .cin (carry_r),
    .s   (fa_s_s),
    .co  (fa_co_s)
  );

  assign last_s = (cnt_r == CNT_LAST);

  // Subtract loads ~b with carry-in 1 (two's complement); add loads b with carry-in 0
`ifdef SERIAL_ADD_SUB_EN
  assign load_b_s = sub ? ~b : b;
  assign load_c_s = sub;
`else
  assign load_b_s = b;
  assign load_c_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode, looking at the next state so busy/done can be registered
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_s)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
      ST_RUN:  busy_nxt_s = 1'b1;
      ST_DONE: done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Handshake output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  // Operand capture, serial shift, and result publication on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_r  <= {WIDTH{1'b0}};
      op_b_r  <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_a_r  <= a;
            op_b_r  <= load_b_s;
            carry_r <= load_c_s;
            res_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        ST_RUN: begin
          op_a_r  <= {1'b0, op_a_r[WIDTH-1:1]};
          op_b_r  <= {1'b0, op_b_r[WIDTH-1:1]};
          res_r   <= {fa_s_s, res_r[WIDTH-1:1]};
          carry_r <= fa_co_s;
          cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          // sum only ever sees the completed word
          if (last_s) begin
            sum_r  <= {fa_s_s, res_r[WIDTH-1:1]};
            cout_r <= fa_co_s;
          end
        end
        ST_DONE: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed, table-driven bench for serial_add_ctrl (WIDTH=4); sub tests when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_vec;
  int n_err;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Issue one start, then watch busy/done and sum stability until one cycle past done.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        output int done_k, output int busy_n, output int sum_moves);
    logic [W-1:0] s0;
    @(negedge clk);
    a = av; b = bv; sub = sv; start = 1'b1;
    s0 = sum;
    @(posedge clk);
    #1 start = 1'b0;
    done_k = -1; busy_n = 0; sum_moves = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) begin
        busy_n++;
        if (sum !== s0) sum_moves++;
      end
      if (done && done_k < 0) done_k = k;
      if (done_k >= 0 && k > done_k) begin
        chk("done_one_cycle", int'(done), 0);
        break;
      end
    end
  endtask

  vec_t vecs[$];
  int   dk, bn, sm, cnt_done, prev_t, bad;

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    n_vec = 0; n_err = 0;

    vecs.push_back('{4'd3,  4'd2,  1'b0, 4'd5,  1'b0});
    vecs.push_back('{4'd15, 4'd1,  1'b0, 4'd0,  1'b1});
    vecs.push_back('{4'd9,  4'd9,  1'b0, 4'd2,  1'b1});
    vecs.push_back('{4'd6,  4'd6,  1'b0, 4'd12, 1'b0});
    vecs.push_back('{4'd0,  4'd0,  1'b0, 4'd0,  1'b0});
    vecs.push_back('{4'd15, 4'd15, 1'b0, 4'd14, 1'b1});
    vecs.push_back('{4'd10, 4'd5,  1'b0, 4'd15, 1'b0});
    vecs.push_back('{4'd8,  4'd8,  1'b0, 4'd0,  1'b1});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{4'd5,  4'd7,  1'b1, 4'd14, 1'b0});
    vecs.push_back('{4'd7,  4'd5,  1'b1, 4'd2,  1'b1});
    vecs.push_back('{4'd5,  4'd5,  1'b1, 4'd0,  1'b1});
`endif

    #12;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_sum",  int'(sum),  0);
    chk("reset_cout", int'(cout), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, dk, bn, sm);
      chk($sformatf("v%0d_done_lat", i), dk, W);
      chk($sformatf("v%0d_busy_cycles", i), bn, W);
      chk($sformatf("v%0d_sum_stable_in_run", i), sm, 0);
      chk($sformatf("v%0d_sum", i), int'(sum), int'(vecs[i].exp_sum));
      chk($sformatf("v%0d_cout", i), int'(cout), int'(vecs[i].exp_cout));
    end

    // 15+1 result holds while idle even as the inputs move
    run_op(4'd15, 4'd1, 1'b0, dk, bn, sm);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a = W'(k + 3); b = W'(k + 5);
      if (sum !== 4'd0 || cout !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("hold_after_done", bad, 0);

    // Operands/start changed during RUN do not affect the operation in flight
    @(negedge clk);
    a = 4'd6; b = 4'd6; start = 1'b1;
    @(posedge clk);
    #1 a = 4'd1; b = 4'd1;
    cnt_done = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 2) start = 1'b0;
      if (done) begin
        cnt_done++;
        chk("inflight_sum",  int'(sum),  12);
        chk("inflight_cout", int'(cout), 0);
      end
    end
    chk("inflight_done_count", cnt_done, 1);

    // Asynchronous reset on the second RUN cycle
    @(negedge clk);
    a = 4'd3; b = 4'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_sum",  int'(sum),  0);
    chk("arst_cout", int'(cout), 0);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done !== 1'b0) bad++;
      if (k == 2) rst_n = 1'b1;
    end
    chk("arst_no_done", bad, 0);
    run_op(4'd9, 4'd9, 1'b0, dk, bn, sm);
    chk("post_rst_lat",  dk, W);
    chk("post_rst_sum",  int'(sum),  2);
    chk("post_rst_cout", int'(cout), 1);

    // start held high: re-trigger every WIDTH+2 cycles
    @(negedge clk);
    a = 4'd1; b = 4'd2; start = 1'b1;
    cnt_done = 0; prev_t = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        cnt_done++;
        chk("cont_sum", int'(sum), 3);
        if (prev_t >= 0) chk("cont_period", k - prev_t, W + 2);
        prev_t = k;
      end
    end
    chk("cont_done_count", cnt_done, 6);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("cont_idle_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
